td4_fetch_decode: RTL

Fetch/decode stage directly downstream of the 4-bit program counter. It consumes the PC value, reads the instruction from a 16x8 program store that can be written while halted, and decodes it. It drives the register-file, output-port and PC load strobes (all active-low), the ALU source select and the immediate. It also owns the carry flag and a HALT/RUN/STEP control FSM, so a program can be loaded and single-stepped before free running.

---
 rtl/td4_fetch_decode_pkg.sv | 64 ++++++
 rtl/td4_fetch_decode_if.sv | 33 +++
 rtl/td4_prog_mem.sv | 30 +++
 rtl/td4_fetch_decode.sv | 97 +++++++++
 4 files changed

// File: rtl/td4_fetch_decode_pkg.sv
// Shared definitions for the TD4 fetch/decode stage: widths, opcode
// constants, ALU source encodings, control FSM states and the decode helper.
package td4_fetch_decode_pkg;

  localparam int DATA_W  = 4;
  localparam int ADDR_W  = 4;
  localparam int OP_W    = 4;
  localparam int INSTR_W = OP_W + DATA_W;
  localparam int DEPTH   = 2 ** ADDR_W;

  // Instruction set; the remaining four codes decode through the same
  // equations and have no special meaning.
  localparam logic [OP_W-1:0] OP_ADD_A_IM = 4'b0000;
  localparam logic [OP_W-1:0] OP_MOV_A_B  = 4'b0001;
  localparam logic [OP_W-1:0] OP_IN_A     = 4'b0010;
  localparam logic [OP_W-1:0] OP_MOV_A_IM = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV_B_A  = 4'b0100;
  localparam logic [OP_W-1:0] OP_ADD_B_IM = 4'b0101;
  localparam logic [OP_W-1:0] OP_IN_B     = 4'b0110;
  localparam logic [OP_W-1:0] OP_MOV_B_IM = 4'b0111;
  localparam logic [OP_W-1:0] OP_OUT_B    = 4'b1001;
  localparam logic [OP_W-1:0] OP_OUT_IM   = 4'b1011;
  localparam logic [OP_W-1:0] OP_JNC      = 4'b1110;
  localparam logic [OP_W-1:0] OP_JMP      = 4'b1111;

  // ALU source select
  typedef enum logic [1:0] {
    SEL_A    = 2'b00,
    SEL_B    = 2'b01,
    SEL_IN   = 2'b10,
    SEL_ZERO = 2'b11
  } sel_t;

  // Control FSM states
  typedef enum logic [1:0] {
    HALT = 2'b00,
    RUN  = 2'b01,
    STEP = 2'b10
  } state_t;

  // Decoded control word; all load strobes are active-low.
  typedef struct packed {
    sel_t sel;
    logic ldAN;
    logic ldBN;
    logic ldOutN;
    logic pcLdN;
  } decode_t;

  // Pure combinational decode of one opcode against the stored carry flag.
  // JNC and JMP fall out of the pcLdN equation: op[0] forces the jump,
  // otherwise it is taken only while the carry flag is clear.
  function automatic decode_t decodeOp(input logic [OP_W-1:0] op,
                                       input logic carryFlag);
    decode_t d;
    d.sel    = sel_t'({op[1], op[0] | op[3]});
    d.ldAN   = op[3] | op[2];
    d.ldBN   = op[3] | ~op[2];
    d.ldOutN = ~op[3] | op[2];
    d.pcLdN  = ~(op[3] & op[2] & (op[0] | ~carryFlag));
    return d;
  endfunction

endpackage

// File: rtl/td4_fetch_decode_if.sv
// Bus between the fetch/decode stage and its surroundings: PC and carry
// coming in, run/step control, program loading, and the decoded strobes.
interface td4_fetch_decode_if;
  import td4_fetch_decode_pkg::*;

  logic [ADDR_W-1:0]  pc;
  logic               carry_in;
  logic               run;
  logic               step;
  logic               prog_we;
  logic [ADDR_W-1:0]  prog_addr;
  logic [INSTR_W-1:0] prog_data;
  logic [DATA_W-1:0]  imm;
  logic [1:0]         sel;
  logic               ld_a_n;
  logic               ld_b_n;
  logic               ld_out_n;
  logic               pc_ld_n;
  logic               carry;
  logic               halted;

  // Driving side: PC/counter, front panel and program loader
  modport master (
    output pc, carry_in, run, step, prog_we, prog_addr, prog_data,
    input  imm, sel, ld_a_n, ld_b_n, ld_out_n, pc_ld_n, carry, halted
  );

  // Fetch/decode stage itself
  modport slave (
    input  pc, carry_in, run, step, prog_we, prog_addr, prog_data,
    output imm, sel, ld_a_n, ld_b_n, ld_out_n, pc_ld_n, carry, halted
  );
endinterface

// File: rtl/td4_prog_mem.sv
// 16x8 program store: synchronous write, asynchronous read, and an
// asynchronous clear on reset so a fresh reset always starts from zeros.
module td4_prog_mem
  import td4_fetch_decode_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [DEPTH];

  // Clear the whole store on reset, otherwise commit one word per write cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/td4_fetch_decode.sv
// TD4 fetch/decode stage: fetches mem[pc], decodes it into the datapath
// strobes, owns the carry flag and the HALT/RUN/STEP control FSM.
module td4_fetch_decode (
  input logic              clk,
  input logic              reset,
  td4_fetch_decode_if.slave bus
);
  import td4_fetch_decode_pkg::*;

  state_t             state;
  state_t             nextState;
  logic               carryReg;
  logic               memWe;
  logic [INSTR_W-1:0] instr;
  logic [OP_W-1:0]    op;
  logic [DATA_W-1:0]  immField;
  decode_t            dec;

  // Loading is only allowed while halted so a running program cannot be
  // corrupted underneath itself.
  assign memWe = bus.prog_we && (state == HALT);

  td4_prog_mem u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (memWe),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (bus.pc),
    .rdata (instr)
  );

  assign op       = instr[INSTR_W-1 -: OP_W];
  assign immField = instr[DATA_W-1:0];
  assign dec      = decodeOp(op, carryReg);

  // Control FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HALT;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: run beats step, step lasts exactly one cycle
  always_comb begin
    nextState = state;
    case (state)
      HALT: begin
        if (bus.run) begin
          nextState = RUN;
        end else if (bus.step) begin
          nextState = STEP;
        end
      end
      RUN: begin
        if (!bus.run) begin
          nextState = HALT;
        end
      end
      STEP:    nextState = HALT;
      default: nextState = HALT;
    endcase
  end

  // Carry flag follows the adder whenever an instruction executes, frozen in HALT
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      carryReg <= 1'b0;
    end else if (state != HALT) begin
      carryReg <= bus.carry_in;
    end
  end

  // Output strobes: in HALT nothing loads and the PC reloads its own value
  always_comb begin
    bus.imm      = bus.pc;
    bus.sel      = SEL_ZERO;
    bus.ld_a_n   = 1'b1;
    bus.ld_b_n   = 1'b1;
    bus.ld_out_n = 1'b1;
    bus.pc_ld_n  = 1'b0;
    if (state != HALT) begin
      bus.imm      = immField;
      bus.sel      = dec.sel;
      bus.ld_a_n   = dec.ldAN;
      bus.ld_b_n   = dec.ldBN;
      bus.ld_out_n = dec.ldOutN;
      bus.pc_ld_n  = dec.pcLdN;
    end
  end

  assign bus.carry  = carryReg;
  assign bus.halted = (state == HALT);

endmodule
